// File: rtl/mem_stage_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_if
// Bundle between EX, the MEM stage and WB.
//   p3_*        : bundle presented by EX (ALU lane + load/store lane)
//   stall, hit  : combinational status back to EX
//   p4_*        : registered bundle handed to WB
// Modports:
//   master : the EX/WB side (drives p3_*, observes stall/hit/p4_*)
//   slave  : the MEM stage itself
// ---------------------------------------------------------------------------
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_W   = 3
);
    logic              p3_valid;
    logic [RD_W-1:0]   p3_alu_rd;
    logic [DATA_W-1:0] p3_alu_aluOut;
    logic [1:0]        p3_mem_op;
    logic [1:0]        p3_mem_size;
    logic              p3_mem_signed;
    logic [RD_W-1:0]   p3_mem_rd;
    logic [ADDR_W-1:0] p3_mem_address;
    logic [DATA_W-1:0] p3_mem_wdata;

    logic              stall;
    logic              hit;

    logic              p4_valid;
    logic [RD_W-1:0]   p4_alu_rd;
    logic [DATA_W-1:0] p4_alu_aluOut;
    logic [RD_W-1:0]   p4_mem_rd;
    logic [DATA_W-1:0] p4_mem_out;
    logic              p4_misalign;

    modport master (
        output p3_valid, p3_alu_rd, p3_alu_aluOut, p3_mem_op, p3_mem_size,
               p3_mem_signed, p3_mem_rd, p3_mem_address, p3_mem_wdata,
        input  stall, hit,
               p4_valid, p4_alu_rd, p4_alu_aluOut, p4_mem_rd, p4_mem_out,
               p4_misalign
    );

    modport slave (
        input  p3_valid, p3_alu_rd, p3_alu_aluOut, p3_mem_op, p3_mem_size,
               p3_mem_signed, p3_mem_rd, p3_mem_address, p3_mem_wdata,
        output stall, hit,
               p4_valid, p4_alu_rd, p4_alu_aluOut, p4_mem_rd, p4_mem_out,
               p4_misalign
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// MEM stage plus MEM/WB pipeline register of the VLIW pipe. Carries one ALU
// lane through untouched and runs one load/store lane against an internal
// little-endian byte memory. A single-line tag models hit/miss; a miss holds
// EX for MISS_LAT extra cycles. Misaligned accesses are flagged and dropped.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_stage_lsu_if.slave (p3_* in, stall/hit/p4_* out)
// DATA_W is expected to be 32; the extension logic assumes a 32-bit word.
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int LINE_BYTES = 16,
    parameter int MISS_LAT   = 3,
    parameter int RD_W       = 3
) (
    input  logic            clk,
    input  logic            reset,
    mem_stage_lsu_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    typedef enum logic {IDLE, MISS} state_t;

    state_t            state;
    logic [CNT_W-1:0]  miss_cnt;
    logic [TAG_W-1:0]  tag;
    logic              tag_valid;

    logic [7:0]        mem [DEPTH];

    logic              is_mem;
    logic              misaligned;
    logic              access;
    logic              line_match;
    logic              miss_start;
    logic              stall_c;
    logic              load_fire;
    logic              store_fire;
    logic [TAG_W-1:0]  access_tag;
    logic [IDX_W-1:0]  idx [4];
    logic [31:0]       rword;
    logic [DATA_W-1:0] load_data;
    logic [RD_W-1:0]   load_rd;

    // Decode of the load/store lane. Op 11 is a no-op, size 11 is a word.
    assign is_mem     = bus.p3_valid && (bus.p3_mem_op == 2'b01 || bus.p3_mem_op == 2'b10);
    assign misaligned = is_mem &&
                        ((bus.p3_mem_size == 2'b01 && bus.p3_mem_address[0]) ||
                         (bus.p3_mem_size[1] && bus.p3_mem_address[1:0] != 2'b00));
    assign access     = is_mem && !misaligned;
    assign access_tag = bus.p3_mem_address[ADDR_W-1:OFF_W];
    assign line_match = tag_valid && (access_tag == tag);
    assign miss_start = access && !line_match && (MISS_LAT != 0);

    // In MISS the last countdown cycle (count 0) is the completing one and
    // does not stall.
    always_comb begin
        stall_c = 1'b0;
        case (state)
            IDLE:    stall_c = miss_start;
            MISS:    stall_c = (miss_cnt != '0);
            default: stall_c = 1'b0;
        endcase
    end

    assign bus.stall  = stall_c;
    assign bus.hit    = access && line_match;
    assign load_fire  = access && !stall_c && (bus.p3_mem_op == 2'b01);
    assign store_fire = access && !stall_c && (bus.p3_mem_op == 2'b10);
    assign load_rd    = load_fire ? bus.p3_mem_rd : '0;

    // Byte lanes wrap modulo DEPTH independently, so a non-power-of-two
    // memory still aliases correctly.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i] = IDX_W'((32'(bus.p3_mem_address) + 32'(i)) % 32'(DEPTH));
        end
    end

    assign rword = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};

    // Size/sign extension of the combinational read.
    always_comb begin
        load_data = '0;
        case (bus.p3_mem_size)
            2'b00:   load_data = {{(DATA_W-8){bus.p3_mem_signed & rword[7]}}, rword[7:0]};
            2'b01:   load_data = {{(DATA_W-16){bus.p3_mem_signed & rword[15]}}, rword[15:0]};
            default: load_data = rword;
        endcase
    end

    // Data memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (store_fire) begin
            mem[idx[0]] <= bus.p3_mem_wdata[7:0];
            if (bus.p3_mem_size != 2'b00) begin
                mem[idx[1]] <= bus.p3_mem_wdata[15:8];
            end
            if (bus.p3_mem_size[1]) begin
                mem[idx[2]] <= bus.p3_mem_wdata[23:16];
                mem[idx[3]] <= bus.p3_mem_wdata[31:24];
            end
        end
    end

    // Miss FSM, line tag and the MEM/WB register. Any stalled cycle writes a
    // bubble so WB never sees a half-finished bundle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            miss_cnt          <= '0;
            tag               <= '0;
            tag_valid         <= 1'b0;
            bus.p4_valid      <= 1'b0;
            bus.p4_alu_rd     <= '0;
            bus.p4_alu_aluOut <= '0;
            bus.p4_mem_rd     <= '0;
            bus.p4_mem_out    <= '0;
            bus.p4_misalign   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        state    <= MISS;
                        miss_cnt <= CNT_W'(MISS_LAT - 1);
                    end
                end
                MISS: begin
                    if (miss_cnt != '0) begin
                        miss_cnt <= miss_cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (access && !stall_c) begin
                tag       <= access_tag;
                tag_valid <= 1'b1;
            end

            if (stall_c || !bus.p3_valid) begin
                bus.p4_valid      <= 1'b0;
                bus.p4_alu_rd     <= '0;
                bus.p4_alu_aluOut <= '0;
                bus.p4_mem_rd     <= '0;
                bus.p4_mem_out    <= '0;
                bus.p4_misalign   <= 1'b0;
            end else begin
                bus.p4_valid      <= 1'b1;
                bus.p4_alu_rd     <= bus.p3_alu_rd;
                bus.p4_alu_aluOut <= bus.p3_alu_aluOut;
                bus.p4_mem_rd     <= load_rd;
                bus.p4_mem_out    <= load_fire ? load_data : '0;
                bus.p4_misalign   <= misaligned;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu. Two instances share one stimulus: the
// main one (MISS_LAT = 3) and a MISS_LAT = 0 build. Address width is 11 bits
// so that 0x440 is a distinct address that wraps onto 0x040 of the 1 KiB
// memory. Expected bundles come from a small reference model (byte memory
// plus single line tag) and flow through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 11;
    localparam int DEPTH      = 1024;
    localparam int LINE_BYTES = 16;
    localparam int MISS_LAT   = 3;
    localparam int RD_W       = 3;

    typedef struct {
        logic        valid;
        logic [2:0]  alu_rd;
        logic [31:0] alu_out;
        logic [2:0]  mem_rd;
        logic [31:0] mem_out;
        logic        misalign;
    } exp_t;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    exp_t       sb [$];
    logic [7:0] ref_mem [int];
    logic       m_tag_valid;
    int         m_tag;

    mem_stage_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();
    mem_stage_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus0 ();

    mem_stage_lsu #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .LINE_BYTES(LINE_BYTES), .MISS_LAT(MISS_LAT), .RD_W(RD_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    mem_stage_lsu #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .LINE_BYTES(LINE_BYTES), .MISS_LAT(0), .RD_W(RD_W)
    ) dut0 (
        .clk(clk),
        .reset(reset),
        .bus(bus0)
    );

    assign bus0.p3_valid       = bus.p3_valid;
    assign bus0.p3_alu_rd      = bus.p3_alu_rd;
    assign bus0.p3_alu_aluOut  = bus.p3_alu_aluOut;
    assign bus0.p3_mem_op      = bus.p3_mem_op;
    assign bus0.p3_mem_size    = bus.p3_mem_size;
    assign bus0.p3_mem_signed  = bus.p3_mem_signed;
    assign bus0.p3_mem_rd      = bus.p3_mem_rd;
    assign bus0.p3_mem_address = bus.p3_mem_address;
    assign bus0.p3_mem_wdata   = bus.p3_mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int a);
        int k;
        k = a % DEPTH;
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    function automatic logic [31:0] model_load(input int a, input logic [1:0] size, input logic sgn);
        logic [31:0] w;
        w = {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
        case (size)
            2'b00:   return sgn ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            2'b01:   return sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic model_store(input int a, input logic [1:0] size, input logic [31:0] wdata);
        int nb;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            ref_mem[(a + i) % DEPTH] = wdata[8*i +: 8];
        end
    endtask

    task automatic set_idle();
        bus.p3_valid       = 1'b0;
        bus.p3_alu_rd      = '0;
        bus.p3_alu_aluOut  = '0;
        bus.p3_mem_op      = 2'b00;
        bus.p3_mem_size    = 2'b00;
        bus.p3_mem_signed  = 1'b0;
        bus.p3_mem_rd      = '0;
        bus.p3_mem_address = '0;
        bus.p3_mem_wdata   = '0;
    endtask

    // Compares both instances' WB bundle against the oldest scoreboard entry.
    task automatic checkOutput();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("p4_valid",     32'(bus.p4_valid),     32'(e.valid));
        check("p4_alu_rd",    32'(bus.p4_alu_rd),    32'(e.alu_rd));
        check("p4_alu_out",   bus.p4_alu_aluOut,     e.alu_out);
        check("p4_mem_rd",    32'(bus.p4_mem_rd),    32'(e.mem_rd));
        check("p4_mem_out",   bus.p4_mem_out,        e.mem_out);
        check("p4_misalign",  32'(bus.p4_misalign),  32'(e.misalign));
        check("lat0_valid",   32'(bus0.p4_valid),    32'(e.valid));
        check("lat0_alu_out", bus0.p4_alu_aluOut,    e.alu_out);
        check("lat0_mem_rd",  32'(bus0.p4_mem_rd),   32'(e.mem_rd));
        check("lat0_mem_out", bus0.p4_mem_out,       e.mem_out);
        check("lat0_misalgn", 32'(bus0.p4_misalign), 32'(e.misalign));
    endtask

    // Drives one bundle at a falling edge, holds it through any stall, then
    // checks stall length, hit and the WB bundle one edge after completion.
    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [1:0] size,
                                 input logic sgn, input logic [10:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] mem_rd, input logic [2:0] alu_rd,
                                 input logic [31:0] alu_out);
        exp_t e;
        logic is_mem, mis, act, exp_hit;
        int   line, idx, exp_stall, cycles;

        is_mem    = valid && (op == 2'b01 || op == 2'b10);
        mis       = is_mem && ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00));
        act       = is_mem && !mis;
        line      = int'(addr) / LINE_BYTES;
        idx       = int'(addr) % DEPTH;
        exp_hit   = act && m_tag_valid && (line == m_tag);
        exp_stall = (act && !exp_hit) ? MISS_LAT : 0;

        e = '{valid: 1'b0, alu_rd: 3'd0, alu_out: 32'd0, mem_rd: 3'd0, mem_out: 32'd0, misalign: 1'b0};
        if (valid) begin
            e.valid    = 1'b1;
            e.alu_rd   = alu_rd;
            e.alu_out  = alu_out;
            e.misalign = mis;
            if (act && op == 2'b01) begin
                e.mem_rd  = mem_rd;
                e.mem_out = model_load(idx, size, sgn);
            end
        end
        if (act) begin
            m_tag       = line;
            m_tag_valid = 1'b1;
            if (op == 2'b10) model_store(idx, size, wdata);
        end
        sb.push_back(e);

        @(negedge clk);
        bus.p3_valid       = valid;
        bus.p3_alu_rd      = alu_rd;
        bus.p3_alu_aluOut  = alu_out;
        bus.p3_mem_op      = op;
        bus.p3_mem_size    = size;
        bus.p3_mem_signed  = sgn;
        bus.p3_mem_rd      = mem_rd;
        bus.p3_mem_address = addr;
        bus.p3_mem_wdata   = wdata;
        #1;
        cycles = 0;
        while (bus.stall === 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            check("bubble_valid", 32'(bus.p4_valid), 32'd0);
            cycles++;
        end
        check("stall_cycles", 32'(cycles), 32'(exp_stall));
        check("hit", 32'(bus.hit), 32'(exp_hit));
        check("lat0_stall", 32'(bus0.stall), 32'd0);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_tag_valid = 1'b0;
        m_tag       = 0;
        reset       = 1'b0;
        set_idle();

        repeat (3) @(negedge clk);
        check("rst_p4_valid",   32'(bus.p4_valid),    32'd0);
        check("rst_p4_alu_rd",  32'(bus.p4_alu_rd),   32'd0);
        check("rst_p4_alu_out", bus.p4_alu_aluOut,    32'd0);
        check("rst_p4_mem_rd",  32'(bus.p4_mem_rd),   32'd0);
        check("rst_p4_mem_out", bus.p4_mem_out,       32'd0);
        check("rst_p4_misalgn", 32'(bus.p4_misalign), 32'd0);
        check("rst_stall",      32'(bus.stall),       32'd0);
        reset = 1'b1;
        $display("[TB] reset released");

        // Cold store then loads of the same word in several widths
        applyStimulus(1, 2'b10, 2'b10, 0, 11'h040, 32'hDEADBEEF, 3'd0, 3'd1, 32'h0000_0011);
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h040, 32'h0,        3'd2, 3'd1, 32'h0000_0021);
        applyStimulus(1, 2'b01, 2'b00, 1, 11'h043, 32'h0,        3'd3, 3'd2, 32'h0000_0031);
        applyStimulus(1, 2'b01, 2'b00, 0, 11'h043, 32'h0,        3'd3, 3'd2, 32'h0000_0032);
        applyStimulus(1, 2'b01, 2'b01, 1, 11'h042, 32'h0,        3'd4, 3'd3, 32'h0000_0041);

        // Misaligned accesses, including one to a cold line
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h041, 32'h0,        3'd4, 3'd5, 32'h0000_0012);
        applyStimulus(1, 2'b10, 2'b10, 0, 11'h301, 32'h0,        3'd0, 3'd6, 32'h0000_0051);
        applyStimulus(1, 2'b10, 2'b01, 0, 11'h043, 32'h0000FFFF, 3'd0, 3'd6, 32'h0000_0052);
        applyStimulus(1, 2'b01, 2'b11, 0, 11'h040, 32'h0,        3'd7, 3'd7, 32'h0000_0061);

        // Store followed immediately by a load of the same bytes
        applyStimulus(1, 2'b10, 2'b00, 0, 11'h045, 32'hAAAA_AA77, 3'd0, 3'd1, 32'h0000_0071);
        applyStimulus(1, 2'b01, 2'b00, 0, 11'h045, 32'h0,         3'd5, 3'd1, 32'h0000_0072);
        applyStimulus(1, 2'b10, 2'b01, 0, 11'h046, 32'h1234_BEEF, 3'd0, 3'd2, 32'h0000_0081);
        applyStimulus(1, 2'b01, 2'b01, 1, 11'h046, 32'h0,         3'd6, 3'd2, 32'h0000_0082);

        // No-op encodings and an invalid bundle
        applyStimulus(1, 2'b00, 2'b10, 0, 11'h041, 32'h0, 3'd3, 3'd6, 32'h0000_0099);
        applyStimulus(1, 2'b11, 2'b10, 0, 11'h041, 32'h0, 3'd3, 3'd4, 32'h0000_009A);
        applyStimulus(0, 2'b01, 2'b10, 0, 11'h040, 32'h0, 3'd3, 3'd4, 32'h0000_009B);

        // Line changes, hit after miss within a line, address wrap
        applyStimulus(1, 2'b10, 2'b10, 0, 11'h050, 32'hCAFEF00D, 3'd0, 3'd1, 32'h0000_00A1);
        applyStimulus(1, 2'b10, 2'b10, 0, 11'h054, 32'h13572468, 3'd0, 3'd1, 32'h0000_00A2);
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h040, 32'h0,        3'd1, 3'd2, 32'h0000_00A3);
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h050, 32'h0,        3'd2, 3'd3, 32'h0000_00A4);
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h054, 32'h0,        3'd3, 3'd4, 32'h0000_00A5);
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h440, 32'h0,        3'd4, 3'd5, 32'h0000_00A6);

        // Asynchronous reset while WB holds a live bundle
        #2;
        reset = 1'b0;
        set_idle();
        #1;
        check("arst_p4_valid",   32'(bus.p4_valid),  32'd0);
        check("arst_p4_mem_out", bus.p4_mem_out,     32'd0);
        check("arst_p4_mem_rd",  32'(bus.p4_mem_rd), 32'd0);
        check("arst_p4_alu_out", bus.p4_alu_aluOut,  32'd0);
        @(negedge clk);
        reset       = 1'b1;
        m_tag_valid = 1'b0;

        // Tag was cleared, memory was not
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h040, 32'h0, 3'd2, 3'd3, 32'h0000_00B1);

        // Reset in the first MISS cycle (count = 2) discards the access
        @(negedge clk);
        bus.p3_valid       = 1'b1;
        bus.p3_alu_rd      = 3'd7;
        bus.p3_alu_aluOut  = 32'h0000_00C1;
        bus.p3_mem_op      = 2'b10;
        bus.p3_mem_size    = 2'b10;
        bus.p3_mem_address = 11'h0C0;
        bus.p3_mem_wdata   = 32'hABCD1234;
        @(posedge clk);
        #1;
        check("miss_stall", 32'(bus.stall), 32'd1);
        #1;
        reset = 1'b0;
        set_idle();
        #1;
        check("mrst_p4_valid", 32'(bus.p4_valid), 32'd0);
        check("mrst_p4_alu",   bus.p4_alu_aluOut, 32'd0);
        check("mrst_stall",    32'(bus.stall),    32'd0);
        @(negedge clk);
        reset       = 1'b1;
        m_tag_valid = 1'b0;
        #1;
        check("post_rst_stall", 32'(bus.stall), 32'd0);

        applyStimulus(1, 2'b10, 2'b10, 0, 11'h0C0, 32'hABCD1234, 3'd0, 3'd7, 32'h0000_00C2);
        applyStimulus(1, 2'b01, 2'b10, 0, 11'h0C0, 32'h0,        3'd6, 3'd7, 32'h0000_00C3);
        applyStimulus(0, 2'b00, 2'b00, 0, 11'h000, 32'h0,        3'd0, 3'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised successor to the VLIW MEM stage and its MEM/WB pipeline register. It carries one ALU lane through unchanged and runs one load/store lane against an internal byte-addressed data memory. The load/store lane supports byte, half and word accesses with sign or zero extension, and stores. A line-tag hit/miss model stalls the front of the pipe on a miss. Misaligned accesses are detected and suppressed. It sits between EX (p3_*) and WB (p4_*).

Parameters:
DATA_W, 32, datapath width; must be 32.
ADDR_W, 10, byte address width.
DEPTH, 1024, data memory size in bytes; addresses wrap modulo DEPTH.
LINE_BYTES, 16, line size for the hit model; power of two.
MISS_LAT, 3, extra stall cycles on a miss; 0 allowed.
RD_W, 3, destination register index width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
p3_valid  in  1  bundle valid from EX.
p3_alu_rd  in  RD_W  ALU-lane destination; 0 = no writeback.
p3_alu_aluOut  in  DATA_W  ALU result.
p3_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
p3_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
p3_mem_signed  in  1  load: 1 = sign-extend, 0 = zero-extend.
p3_mem_rd  in  RD_W  load destination.
p3_mem_address  in  ADDR_W  byte address.
p3_mem_wdata  in  DATA_W  store data; low bytes used.
stall  out  1  combinational; EX must hold all p3_* stable while high.
hit  out  1  combinational; current access hits the tagged line.
p4_valid  out  1  WB bundle valid.
p4_alu_rd  out  RD_W  registered.
p4_alu_aluOut  out  DATA_W  registered.
p4_mem_rd  out  RD_W  registered; 0 for stores, misaligned accesses and no-ops.
p4_mem_out  out  DATA_W  registered extended load data; 0 when no load.
p4_misalign  out  1  registered misalignment flag.

Behaviour:
- Reset (async, active-low): all p4_* = 0, FSM = IDLE, miss counter = 0, tag_valid = 0. Memory contents are not reset. An in-flight miss and any pending store are discarded.
- Access is active when p3_valid is high, op is load or store, and the address is aligned.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
- Line match: tag_valid, and addr[ADDR_W-1:log2(LINE_BYTES)] equals the stored tag.
- hit = active access AND line match.
- FSM IDLE:
  - Active hit: stall = 0; memory access and p4 update at the next edge; latency 1.
  - Active miss with MISS_LAT > 0: stall = 1; go to MISS with count = MISS_LAT - 1; p4 takes a bubble (all p4_* = 0).
  - Active miss with MISS_LAT = 0: behaves as a hit, but hit = 0 and the tag is updated.
- FSM MISS:
  - stall = 1 while count > 0; count decrements each cycle; a bubble is written to p4 each cycle.
  - When count = 0: stall = 0, the tag is loaded and tag_valid set, the access completes at that edge, and the FSM returns to IDLE.
  - Miss latency totals MISS_LAT + 1 cycles.
- Memory and data format:
  - Little-endian; address index = addr mod DEPTH.
  - A store writes 1, 2 or 4 bytes at the completing edge.
  - A load reads combinationally and is extended to DATA_W per size and p3_mem_signed.
  - A load in the cycle after a store to the same address returns the stored data.
- Misaligned bundle: no memory access, no stall, tag unchanged, p4_misalign = 1, p4_mem_rd = 0, p4_mem_out = 0. The ALU lane passes normally.
- ALU lane: registered on the same edge as the mem lane. A stalled bundle's ALU result appears only on completion.
- p3_valid = 0: p4_* = 0 next edge; FSM unaffected in IDLE.
- p3_mem_op = none: 1-cycle pass-through.

Test Plan:
1. reset low mid-MISS with count = 2 -> all p4_* = 0 immediately; stall = 0 after release; the next access to the same line misses again.
2. Store word 0xDEADBEEF at 0x040 (cold) -> stall high 3 cycles, p4_valid = 0 during them; then load word 0x040 -> hit = 1, p4_mem_out = 0xDEADBEEF one cycle later.
3. Load byte 0x043, signed, after step 2 -> p4_mem_out = 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x042 signed -> 0xFFFFDEAD.
4. Load word 0x041 -> p4_misalign = 1, p4_mem_rd = 0, p4_mem_out = 0, stall never high; ALU lane rd = 5, aluOut = 0x12 appears in the same cycle.
5. Load 0x050 (new line) then 0x054 -> first takes 4 cycles, second 1 cycle with hit = 1; address 0x440 aliases to 0x040 data (wrap); MISS_LAT = 0 build -> no stall on any access.
